// File: rtl/cpu_ctrl_mc.sv
// Multicycle controller for the lab datapath: Moore FSM with a memory
// ready handshake, wait-state timeout, flag-conditional branches, HALT and FAULT.
module cpu_ctrl_mc #(
    parameter int WAIT_W          = 4,
    parameter int TIMEOUT         = 15,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    input  logic [2:0] flags,
    input  logic       mem_ready,
    output logic       loadir,
    output logic       loadpc,
    output logic       pcsel,
    output logic       msel,
    output logic       mread,
    output logic       mwrite,
    output logic [1:0] nsel,
    output logic [1:0] vsel,
    output logic       write,
    output logic       asel,
    output logic       bsel,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       halted,
    output logic       fault
);

    typedef enum logic [3:0] {
        S_RST, S_FETCH, S_INCPC, S_DECODE, S_READB, S_EXEC,
        S_STRD, S_MEM, S_WB, S_HALTED, S_FAULT
    } state_t;

    localparam logic [WAIT_W-1:0] TO_VAL = WAIT_W'(TIMEOUT);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    logic is_movi, is_movr, is_mvn, is_alu_ab, is_cmp, is_ldr, is_str, is_b, is_halt;
    logic br_taken, timeout_hit;

    always_comb begin
        is_movi   = (opcode == 3'b110) && (op == 2'b10);
        is_movr   = (opcode == 3'b110) && (op == 2'b00);
        is_mvn    = (opcode == 3'b101) && (op == 2'b11);
        is_alu_ab = (opcode == 3'b101) && (op != 2'b11);
        is_cmp    = (opcode == 3'b101) && (op == 2'b01);
        is_ldr    = (opcode == 3'b011) && (op == 2'b00);
        is_str    = (opcode == 3'b100) && (op == 2'b00);
        is_b      = (opcode == 3'b001);
        is_halt   = (opcode == 3'b111);
        // flags = {Z, N, V}
        case (op)
            2'b00:   br_taken = 1'b1;
            2'b01:   br_taken = flags[2];
            2'b10:   br_taken = !flags[2];
            default: br_taken = flags[1] ^ flags[0];
        endcase
        timeout_hit = (TIMEOUT != 0) && !mem_ready && (wait_q == TO_VAL);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_RST;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:   state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ready)        state_d = S_INCPC;
                else if (timeout_hit) state_d = S_FAULT;
            end
            S_INCPC: state_d = S_DECODE;
            S_DECODE: begin
                if (is_movi || is_b)             state_d = S_FETCH;
                else if (is_movr || is_mvn)      state_d = S_EXEC;
                else if (is_alu_ab)              state_d = S_READB;
                else if (is_ldr || is_str)       state_d = S_EXEC;
                else if (is_halt)                state_d = S_HALTED;
                else if (HALT_ON_ILLEGAL)        state_d = S_FAULT;
                else                             state_d = S_FETCH;
            end
            S_READB: state_d = S_EXEC;
            S_EXEC: begin
                if (is_cmp)                              state_d = S_FETCH;
                else if (is_ldr)                         state_d = S_MEM;
                else if (is_str)                         state_d = S_STRD;
                else if (is_alu_ab || is_mvn || is_movr) state_d = S_WB;
                else                                     state_d = S_FETCH;
            end
            S_STRD:  state_d = S_MEM;
            S_MEM: begin
                if (mem_ready)        state_d = S_FETCH;
                else if (timeout_hit) state_d = S_FAULT;
            end
            S_WB:     state_d = S_FETCH;
            S_HALTED: state_d = S_HALTED;
            S_FAULT:  state_d = S_FAULT;
            default:  state_d = S_RST;
        endcase
    end

    // Wait counter restarts on any state change and saturates while stalled.
    always_comb begin
        wait_d = wait_q;
        if (state_d != state_q)
            wait_d = '0;
        else if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready && (wait_q != '1))
            wait_d = wait_q + 1'b1;
    end

    always_comb begin
        loadir = 1'b0; loadpc = 1'b0; pcsel = 1'b0;
        msel   = 1'b0; mread  = 1'b0; mwrite = 1'b0;
        nsel   = 2'b00; vsel  = 2'b00;
        write  = 1'b0; asel   = 1'b0; bsel   = 1'b0;
        loada  = 1'b0; loadb  = 1'b0; loadc  = 1'b0; loads = 1'b0;
        halted = 1'b0; fault  = 1'b0;
        case (state_q)
            S_FETCH: begin
                mread  = 1'b1;
                loadir = mem_ready;
            end
            S_INCPC: loadpc = 1'b1;
            S_DECODE: begin
                if (is_movi) begin
                    vsel  = 2'b01;
                    write = 1'b1;
                end else if (is_movr || is_mvn) begin
                    nsel  = 2'b10;
                    loadb = 1'b1;
                end else if (is_alu_ab || is_ldr || is_str) begin
                    loada = 1'b1;
                end else if (is_b && br_taken) begin
                    loadpc = 1'b1;
                    pcsel  = 1'b1;
                end
            end
            S_READB: begin
                nsel  = 2'b10;
                loadb = 1'b1;
            end
            S_EXEC: begin
                if (is_cmp) begin
                    loads = 1'b1;
                end else if (is_movr) begin
                    asel  = 1'b1;
                    loadc = 1'b1;
                end else if (is_alu_ab || is_mvn) begin
                    loadc = 1'b1;
                end else if (is_ldr || is_str) begin
                    bsel  = 1'b1;
                    loadc = 1'b1;
                end
            end
            S_STRD: begin
                nsel  = 2'b01;
                loadb = 1'b1;
            end
            S_MEM: begin
                msel = 1'b1;
                if (is_str) begin
                    mwrite = 1'b1;
                end else begin
                    mread = 1'b1;
                    if (mem_ready) begin
                        nsel  = 2'b01;
                        write = 1'b1;
                    end
                end
            end
            S_WB: begin
                nsel  = 2'b01;
                vsel  = 2'b11;
                write = 1'b1;
            end
            S_HALTED: halted = 1'b1;
            S_FAULT:  fault  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_ctrl_mc.sv
// Scoreboard bench for cpu_ctrl_mc: the driver expands each instruction into its
// expected per-cycle control vectors; a negedge monitor compares both instances.
module tb_cpu_ctrl_mc;

    typedef logic [18:0] vec_t;
    localparam vec_t M_LOADIR = vec_t'(1) << 18;
    localparam vec_t M_LOADPC = vec_t'(1) << 17;
    localparam vec_t M_PCSEL  = vec_t'(1) << 16;
    localparam vec_t M_MSEL   = vec_t'(1) << 15;
    localparam vec_t M_MREAD  = vec_t'(1) << 14;
    localparam vec_t M_MWRITE = vec_t'(1) << 13;
    localparam vec_t NS_RD    = vec_t'(1) << 11;
    localparam vec_t NS_RM    = vec_t'(2) << 11;
    localparam vec_t VS_IMM   = vec_t'(1) << 9;
    localparam vec_t VS_C     = vec_t'(3) << 9;
    localparam vec_t M_WRITE  = vec_t'(1) << 8;
    localparam vec_t M_ASEL   = vec_t'(1) << 7;
    localparam vec_t M_BSEL   = vec_t'(1) << 6;
    localparam vec_t M_LOADA  = vec_t'(1) << 5;
    localparam vec_t M_LOADB  = vec_t'(1) << 4;
    localparam vec_t M_LOADC  = vec_t'(1) << 3;
    localparam vec_t M_LOADS  = vec_t'(1) << 2;
    localparam vec_t M_HALTED = vec_t'(1) << 1;
    localparam vec_t M_FAULT  = vec_t'(1);

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] opcode = 3'b000;
    logic [1:0] op = 2'b00;
    logic [2:0] flags = 3'b000;
    logic       mem_ready = 1'b0;
    logic [2:0] nxt_opcode = 3'b000;
    logic [1:0] nxt_op = 2'b00;
    logic [2:0] nxt_flags = 3'b000;

    logic       a_loadir, a_loadpc, a_pcsel, a_msel, a_mread, a_mwrite;
    logic [1:0] a_nsel, a_vsel;
    logic       a_write, a_asel, a_bsel, a_loada, a_loadb, a_loadc, a_loads, a_halted, a_fault;
    logic       b_loadir, b_loadpc, b_pcsel, b_msel, b_mread, b_mwrite;
    logic [1:0] b_nsel, b_vsel;
    logic       b_write, b_asel, b_bsel, b_loada, b_loadb, b_loadc, b_loads, b_halted, b_fault;
    vec_t       vec_a, vec_b;

    always #5 clk = ~clk;

    cpu_ctrl_mc dut (
        .clk(clk), .reset(reset), .opcode(opcode), .op(op), .flags(flags), .mem_ready(mem_ready),
        .loadir(a_loadir), .loadpc(a_loadpc), .pcsel(a_pcsel), .msel(a_msel), .mread(a_mread),
        .mwrite(a_mwrite), .nsel(a_nsel), .vsel(a_vsel), .write(a_write), .asel(a_asel),
        .bsel(a_bsel), .loada(a_loada), .loadb(a_loadb), .loadc(a_loadc), .loads(a_loads),
        .halted(a_halted), .fault(a_fault)
    );

    cpu_ctrl_mc #(.HALT_ON_ILLEGAL(1'b0)) dut_nop (
        .clk(clk), .reset(reset), .opcode(opcode), .op(op), .flags(flags), .mem_ready(mem_ready),
        .loadir(b_loadir), .loadpc(b_loadpc), .pcsel(b_pcsel), .msel(b_msel), .mread(b_mread),
        .mwrite(b_mwrite), .nsel(b_nsel), .vsel(b_vsel), .write(b_write), .asel(b_asel),
        .bsel(b_bsel), .loada(b_loada), .loadb(b_loadb), .loadc(b_loadc), .loads(b_loads),
        .halted(b_halted), .fault(b_fault)
    );

    assign vec_a = {a_loadir, a_loadpc, a_pcsel, a_msel, a_mread, a_mwrite, a_nsel, a_vsel,
                    a_write, a_asel, a_bsel, a_loada, a_loadb, a_loadc, a_loads, a_halted, a_fault};
    assign vec_b = {b_loadir, b_loadpc, b_pcsel, b_msel, b_mread, b_mwrite, b_nsel, b_vsel,
                    b_write, b_asel, b_bsel, b_loada, b_loadb, b_loadc, b_loads, b_halted, b_fault};

    typedef struct {
        vec_t  ea;
        vec_t  eb;
        string tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_instr = 0;

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (vec_a === e.ea) n_pass++;
            else $display("FAIL %s main: got %b required %b", e.tag, vec_a, e.ea);
            n_checks++;
            if (vec_b === e.eb) n_pass++;
            else $display("FAIL %s nop: got %b required %b", e.tag, vec_b, e.eb);
        end
    end

    // One clock cycle: apply inputs just after the edge and queue what both DUTs must show.
    task automatic cyc2(input vec_t ea, input vec_t eb, input logic rdy, input logic rst_n, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        opcode    = nxt_opcode;
        op        = nxt_op;
        flags     = nxt_flags;
        mem_ready = rdy;
        reset     = rst_n;
        e.ea = ea; e.eb = eb; e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input vec_t e, input logic rdy, input logic rst_n, input string tag);
        cyc2(e, e, rdy, rst_n, tag);
    endtask

    task automatic hold_then_reset(input vec_t ea, input vec_t eb, input int n, input bit rnd_rdy, input string tag);
        for (int k = 0; k < n; k++)
            cyc2(ea, eb, rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b0, (k == n - 1) ? 1'b0 : 1'b1, tag);
        cyc(vec_t'(0), 1'($urandom_range(0, 1)), 1'b1, {tag, "_rst"});
    endtask

    // Expand one instruction into its phase list, then play it cycle by cycle.
    // fw/mw: wait states for fetch/data access (-1 = random 0..4).
    task automatic run_instr(input logic [2:0] opc, input logic [1:0] o, input logic [2:0] f,
                             input int fw, input int mw, input bit rst_mid);
        vec_t  ph_v[$];
        vec_t  ph_done[$];
        bit    ph_mem[$];
        string nm;
        bit    halt_k, ill_k, taken;
        int    w;
        halt_k = 1'b0; ill_k = 1'b0;
        nxt_opcode = opc; nxt_op = o; nxt_flags = f;
        n_instr++;
        ph_v.push_back(M_MREAD);  ph_done.push_back(M_MREAD | M_LOADIR); ph_mem.push_back(1'b1);
        ph_v.push_back(M_LOADPC); ph_done.push_back(M_LOADPC);           ph_mem.push_back(1'b0);
        casez ({opc, o})
            5'b110_10: begin nm = "MOVI";
                ph_v.push_back(VS_IMM | M_WRITE); ph_done.push_back(VS_IMM | M_WRITE); ph_mem.push_back(1'b0);
            end
            5'b110_00, 5'b101_11: begin nm = (opc == 3'b110) ? "MOVR" : "MVN";
                ph_v.push_back(NS_RM | M_LOADB); ph_done.push_back(NS_RM | M_LOADB); ph_mem.push_back(1'b0);
                ph_v.push_back(opc == 3'b110 ? (M_ASEL | M_LOADC) : M_LOADC);
                ph_done.push_back(ph_v[3]); ph_mem.push_back(1'b0);
                ph_v.push_back(NS_RD | VS_C | M_WRITE); ph_done.push_back(NS_RD | VS_C | M_WRITE); ph_mem.push_back(1'b0);
            end
            5'b101_??: begin nm = (o == 2'b01) ? "CMP" : ((o == 2'b00) ? "ADD" : "AND");
                ph_v.push_back(M_LOADA);         ph_done.push_back(M_LOADA);         ph_mem.push_back(1'b0);
                ph_v.push_back(NS_RM | M_LOADB); ph_done.push_back(NS_RM | M_LOADB); ph_mem.push_back(1'b0);
                if (o == 2'b01) begin
                    ph_v.push_back(M_LOADS); ph_done.push_back(M_LOADS); ph_mem.push_back(1'b0);
                end else begin
                    ph_v.push_back(M_LOADC); ph_done.push_back(M_LOADC); ph_mem.push_back(1'b0);
                    ph_v.push_back(NS_RD | VS_C | M_WRITE); ph_done.push_back(NS_RD | VS_C | M_WRITE); ph_mem.push_back(1'b0);
                end
            end
            5'b011_00: begin nm = "LDR";
                ph_v.push_back(M_LOADA);          ph_done.push_back(M_LOADA);          ph_mem.push_back(1'b0);
                ph_v.push_back(M_BSEL | M_LOADC); ph_done.push_back(M_BSEL | M_LOADC); ph_mem.push_back(1'b0);
                ph_v.push_back(M_MSEL | M_MREAD);
                ph_done.push_back(M_MSEL | M_MREAD | NS_RD | M_WRITE); ph_mem.push_back(1'b1);
            end
            5'b100_00: begin nm = "STR";
                ph_v.push_back(M_LOADA);          ph_done.push_back(M_LOADA);          ph_mem.push_back(1'b0);
                ph_v.push_back(M_BSEL | M_LOADC); ph_done.push_back(M_BSEL | M_LOADC); ph_mem.push_back(1'b0);
                ph_v.push_back(NS_RD | M_LOADB);  ph_done.push_back(NS_RD | M_LOADB);  ph_mem.push_back(1'b0);
                ph_v.push_back(M_MSEL | M_MWRITE); ph_done.push_back(M_MSEL | M_MWRITE); ph_mem.push_back(1'b1);
            end
            5'b001_??: begin nm = "B";
                case (o)
                    2'b00:   taken = 1'b1;
                    2'b01:   taken = f[2];
                    2'b10:   taken = !f[2];
                    default: taken = (f[1] != f[0]);
                endcase
                ph_v.push_back(taken ? (M_LOADPC | M_PCSEL) : vec_t'(0));
                ph_done.push_back(ph_v[2]); ph_mem.push_back(1'b0);
            end
            5'b111_??: begin nm = "HALT"; halt_k = 1'b1;
                ph_v.push_back(vec_t'(0)); ph_done.push_back(vec_t'(0)); ph_mem.push_back(1'b0);
            end
            default: begin nm = "ILL"; ill_k = 1'b1;
                ph_v.push_back(vec_t'(0)); ph_done.push_back(vec_t'(0)); ph_mem.push_back(1'b0);
            end
        endcase
        for (int i = 0; i < ph_v.size(); i++) begin
            string tag;
            tag = $sformatf("%s#%0d.p%0d", nm, n_instr, i);
            if (ph_mem[i]) begin
                w = (i == 0) ? fw : mw;
                if (w < 0) w = int'($urandom_range(0, 4));
                for (int k = 0; k < w; k++) begin
                    if (rst_mid && i != 0 && k == 1) begin
                        cyc(ph_v[i], 1'b0, 1'b0, tag);
                        cyc(vec_t'(0), 1'($urandom_range(0, 1)), 1'b0, "rst1");
                        cyc(vec_t'(0), 1'($urandom_range(0, 1)), 1'b0, "rst2");
                        cyc(vec_t'(0), 1'($urandom_range(0, 1)), 1'b1, "rst3");
                        return;
                    end
                    cyc(ph_v[i], 1'b0, 1'b1, tag);
                end
                cyc(ph_done[i], 1'b1, 1'b1, tag);
            end else begin
                cyc(ph_v[i], 1'($urandom_range(0, 1)), 1'b1, tag);
            end
        end
        if (halt_k) hold_then_reset(M_HALTED, M_HALTED, 4, 1'b1, "halted");
        if (ill_k)  hold_then_reset(M_FAULT, M_MREAD, 4, 1'b0, "illegal");
    endtask

    logic [2:0] r_opc [9] = '{3'b110, 3'b110, 3'b101, 3'b101, 3'b101, 3'b101, 3'b011, 3'b100, 3'b001};
    logic [1:0] r_op  [9] = '{2'b10, 2'b00, 2'b11, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00};

    initial begin
        int idx;
        logic [1:0] bo;
        cyc(vec_t'(0), 1'b0, 1'b0, "por1");
        cyc(vec_t'(0), 1'b0, 1'b0, "por2");
        cyc(vec_t'(0), 1'b0, 1'b1, "por3");

        run_instr(3'b101, 2'b00, 3'b000, 0, 0, 1'b0);
        run_instr(3'b101, 2'b00, 3'b000, 0, 0, 1'b0);
        run_instr(3'b001, 2'b01, 3'b100, -1, -1, 1'b0);
        run_instr(3'b001, 2'b01, 3'b011, -1, -1, 1'b0);
        run_instr(3'b011, 2'b00, 3'b000, 2, 5, 1'b0);
        run_instr(3'b100, 2'b00, 3'b000, -1, 3, 1'b1);
        run_instr(3'b110, 2'b10, 3'b000, 0, 0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            idx = int'($urandom_range(0, 8));
            bo  = (idx == 8) ? 2'($urandom_range(0, 3)) : r_op[idx];
            run_instr(r_opc[idx], bo, 3'($urandom_range(0, 7)), -1, -1, 1'b0);
        end

        // Fetch stuck: 16 stalled cycles, then sticky fault.
        nxt_opcode = 3'b110; nxt_op = 2'b10;
        for (int k = 0; k < 16; k++) cyc(M_MREAD, 1'b0, 1'b1, $sformatf("to_stall%0d", k));
        hold_then_reset(M_FAULT, M_FAULT, 5, 1'b1, "timeout_fault");
        run_instr(3'b110, 2'b10, 3'b000, 15, 0, 1'b0);
        run_instr(3'b011, 2'b00, 3'b000, 0, 15, 1'b0);

        run_instr(3'b111, 2'($urandom_range(0, 3)), 3'b000, -1, -1, 1'b0);
        run_instr(3'b000, 2'($urandom_range(0, 3)), 3'b000, -1, -1, 1'b0);
        run_instr(3'b011, 2'b01, 3'b000, -1, -1, 1'b0);
        run_instr(3'b110, 2'b11, 3'b000, -1, -1, 1'b0);
        run_instr(3'b100, 2'b10, 3'b000, -1, -1, 1'b0);
        run_instr(3'b101, 2'b01, 3'b000, 0, 0, 1'b0);

        repeat (2) @(negedge clk);
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending entries required 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cpu_ctrl_mc.md
Name: cpu_ctrl_mc

Overview:
Next-generation multicycle controller for the lab datapath. It adds a memory ready/valid handshake with a wait-state timeout, conditional branches on status flags, HALT, illegal-opcode handling and a fault state. It sits between instruction memory/RAM, the instruction register and the datapath. It drives register-file, ALU-operand, PC and memory controls.

Parameters:
WAIT_W, 4, width of the memory wait-state counter.
TIMEOUT, 15, wait cycles tolerated before FAULT; 0 disables the timeout; must be < 2^WAIT_W.
HALT_ON_ILLEGAL, 1, 1: an illegal opcode enters FAULT; 0: it is a NOP (DECODE -> FETCH).

Ports:
clk  in  1  clock; all state changes on rising edge.
reset  in  1  synchronous, active-low reset.
opcode  in  3  IR[15:13].
op  in  2  IR[12:11]; ALU op, MOV form, or branch condition.
flags  in  3  {Z,N,V} from status register.
mem_ready  in  1  memory completes the current read or write this cycle.
loadir, loadpc, pcsel  out  1  IR load; PC load; PC source (0 = PC+1, 1 = branch target).
msel, mread, mwrite  out  1  address source (0 = PC, 1 = C); read request; write request.
nsel  out  2  00 Rn, 01 Rd, 10 Rm.
vsel  out  2  00 mem data, 01 immediate, 11 C.
write, asel, bsel, loada, loadb, loadc, loads  out  1  datapath controls.
halted, fault  out  1  sticky status.

Behaviour:
- Moore FSM. Outputs are decoded from the state register, opcode/op and flags. Only loadir and the MEM outputs also depend on mem_ready. Every output not listed for a state is 0.
- Reset: reset==0 at a clock edge -> state RST, wait counter 0. This takes priority over everything, including mid-MEM, HALTED and FAULT.
- RST: all outputs 0, including halted and fault. Always goes to FETCH next.
- FETCH: mread=1, msel=0.
  - loadir=mem_ready.
  - On mem_ready, go to INCPC.
- INCPC: loadpc=1, pcsel=0 -> DECODE.
- DECODE:
  - MOV imm (110/10): nsel=00, vsel=01, write=1 -> FETCH.
  - MOV reg (110/00) and MVN (101/11): nsel=10, loadb=1 -> EXEC.
  - ADD (101/00), CMP (101/01), AND (101/10): nsel=00, loada=1 -> READB.
  - LDR (011/00) and STR (100/00): nsel=00, loada=1 -> EXEC.
  - B (001): condition by op: 00 always, 01 Z, 10 !Z, 11 N^V.
    - Taken: loadpc=1, pcsel=1 -> FETCH.
    - Not taken: -> FETCH.
  - HALT (111, any op) -> HALTED.
  - Any other opcode/op combination is illegal -> FAULT or FETCH, per HALT_ON_ILLEGAL.
- READB: nsel=10, loadb=1 -> EXEC.
- EXEC:
  - CMP: loads=1 -> FETCH.
  - ADD, AND, MVN: loadc=1 -> WB.
  - MOV reg: asel=1, loadc=1 -> WB.
  - LDR: bsel=1, loadc=1 -> MEM.
  - STR: bsel=1, loadc=1 -> STRD.
- STRD: nsel=01, loadb=1 -> MEM.
- MEM: msel=1.
  - LDR: mread=1; on mem_ready also nsel=01, vsel=00, write=1 -> FETCH.
  - STR: mwrite=1 held until mem_ready -> FETCH.
- WB: nsel=01, vsel=11, write=1 -> FETCH.
- HALTED: halted=1. Stays until reset.
- FAULT: fault=1. Stays until reset.
- Wait counter:
  - Cleared on every state change.
  - Increments each cycle spent in FETCH or MEM with mem_ready==0; saturates at all-ones.
  - With TIMEOUT!=0, the cycle it equals TIMEOUT with mem_ready still 0 -> FAULT next, with no write/load pulse.
  - mem_ready==1 in the same cycle as the limit wins: the access completes normally.
- Latency with zero memory wait states:
  - MOV imm and B: 3 cycles.
  - CMP: 5 cycles.
  - ADD: 6 cycles.
  - LDR: 5 cycles.
  - STR: 6 cycles.
- mwrite and mread are never both 1. write and loadpc are never both 1.

Test Plan:
- Reset held low 3 cycles during a stalled STR MEM -> all outputs 0 in RST. Release -> FETCH with mread=1 the next cycle and mwrite=0.
- mem_ready=1 always, opcode=101 op=00 -> sequence FETCH(loadir) INCPC(loadpc) DECODE(loada, nsel=00) READB(loadb, nsel=10) EXEC(loadc) WB(write, nsel=01, vsel=11). Repeats every 6 cycles.
- Branch: opcode=001 op=01. Z=1 -> loadpc=1, pcsel=1 in DECODE. Z=0 -> no loadpc in DECODE. Both return to FETCH.
- LDR with mem_ready low for 5 cycles in MEM -> msel=1 and mread=1 held 6 cycles. write=1 with vsel=00 only on the ready cycle.
- TIMEOUT=15, mem_ready stuck 0 in FETCH -> fault=1 after 16 FETCH cycles. Stays set until reset. Ready arriving on the 16th cycle instead gives a normal loadir.
- opcode=111 -> halted=1 persists. opcode=000 with HALT_ON_ILLEGAL=1 -> fault=1. With HALT_ON_ILLEGAL=0 -> returns to FETCH after 3 cycles.
